// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bus_bridge
//  Brief    : UART byte-stream to bus-master bridge. Host frames are
//             CMD ('R'/'W'), address bytes, [write data bytes], [CSUM].
//             One bus transaction is issued per frame. A status byte is
//             returned, followed by read data when the read succeeds.
//  Options  : UART_BRIDGE_CHECKSUM_EN -- XOR checksum on frames and read replies
//  Revision : 1.0 - initial release
// ============================================================================
module uart_bus_bridge #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_TIMEOUT = 1024,
    parameter int RX_TIMEOUT  = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_busy,
    output logic [ADDR_WIDTH-1:0] o_bus_address,
    output logic [DATA_WIDTH-1:0] o_bus_data,
    output logic                  o_bus_rnw,
    output logic                  o_bus_en,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    input  logic                  i_bus_done,
    output logic                  o_busy
);

    localparam int         c_BT_W      = $clog2(BUS_TIMEOUT + 1);
    localparam int         c_RT_W      = $clog2(RX_TIMEOUT + 1);
    localparam logic [7:0] c_ADDR_LAST = 8'(ADDR_WIDTH / 8 - 1);
    localparam logic [7:0] c_DATA_LAST = 8'(DATA_WIDTH / 8 - 1);
    localparam logic [c_BT_W-1:0] c_BUS_LAST = c_BT_W'(BUS_TIMEOUT - 1);
    localparam logic [c_RT_W-1:0] c_RX_LAST  = c_RT_W'(RX_TIMEOUT - 1);

    localparam logic [7:0] c_CMD_RD = 8'h52;
    localparam logic [7:0] c_CMD_WR = 8'h57;
    localparam logic [7:0] c_ST_OK  = 8'h4B;
    localparam logic [7:0] c_ST_ERR = 8'h45;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RX_ADDR = 3'd1;
    localparam logic [2:0] c_RX_DATA = 3'd2;
    localparam logic [2:0] c_BUS     = 3'd3;
    localparam logic [2:0] c_TX_STAT = 3'd4;
    localparam logic [2:0] c_TX_DATA = 3'd5;
`ifdef UART_BRIDGE_CHECKSUM_EN
    localparam logic [2:0] c_RX_CSUM = 3'd6;
    localparam logic [2:0] c_TX_CSUM = 3'd7;
    localparam logic [7:0] c_ST_CSUM = 8'h43;
`endif

    logic [2:0]            state_q,    state_d;
    logic [7:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic                  is_read_q,  is_read_d;
    logic [7:0]            csum_q,     csum_d;
    logic [c_RT_W-1:0]     rx_tmo_q,   rx_tmo_d;
    logic [c_BT_W-1:0]     bus_tmo_q,  bus_tmo_d;
    logic                  bus_en_q,   bus_en_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q,  tx_data_d;

    // Frame is complete and verified: request handed to the bus next cycle.
    logic       w_start_bus;
    // A status byte must be presented; w_status selects which one.
    logic       w_start_tx;
    logic [7:0] w_status;

    // Next-state logic for frame reception, bus request and reply transmission.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        is_read_d   = is_read_q;
        csum_d      = csum_q;
        rx_tmo_d    = rx_tmo_q;
        bus_tmo_d   = bus_tmo_q;
        bus_en_d    = bus_en_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        w_start_bus = 1'b0;
        w_start_tx  = 1'b0;
        w_status    = c_ST_OK;

        case (state_q)
            c_IDLE: begin
                // Anything but a command byte is dropped here.
                if (i_rx_valid && (i_rx_data == c_CMD_RD || i_rx_data == c_CMD_WR)) begin
                    is_read_d  = (i_rx_data == c_CMD_RD);
                    csum_d     = i_rx_data;
                    byte_cnt_d = 8'd0;
                    rx_tmo_d   = '0;
                    state_d    = c_RX_ADDR;
                end
            end
`ifdef UART_BRIDGE_CHECKSUM_EN
            c_RX_ADDR, c_RX_DATA, c_RX_CSUM: begin
`else
            c_RX_ADDR, c_RX_DATA: begin
`endif
                if (i_rx_valid) begin
                    rx_tmo_d = '0;
                    csum_d   = csum_q ^ i_rx_data;
                    if (state_q == c_RX_ADDR) begin
                        addr_d = (addr_q << 8) | ADDR_WIDTH'(i_rx_data);
                        if (byte_cnt_q == c_ADDR_LAST) begin
                            byte_cnt_d = 8'd0;
                            if (!is_read_q) begin
                                state_d = c_RX_DATA;
                            end else begin
`ifdef UART_BRIDGE_CHECKSUM_EN
                                state_d = c_RX_CSUM;
`else
                                w_start_bus = 1'b1;
`endif
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end else if (state_q == c_RX_DATA) begin
                        data_d = (data_q << 8) | DATA_WIDTH'(i_rx_data);
                        if (byte_cnt_q == c_DATA_LAST) begin
                            byte_cnt_d = 8'd0;
`ifdef UART_BRIDGE_CHECKSUM_EN
                            state_d = c_RX_CSUM;
`else
                            w_start_bus = 1'b1;
`endif
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
`ifdef UART_BRIDGE_CHECKSUM_EN
                    else begin
                        // Received byte must equal the XOR of everything before it.
                        if (i_rx_data == csum_q) begin
                            w_start_bus = 1'b1;
                        end else begin
                            w_start_tx = 1'b1;
                            w_status   = c_ST_CSUM;
                        end
                    end
`endif
                end else if (rx_tmo_q == c_RX_LAST) begin
                    // Host went silent mid-frame: abandon it without a reply.
                    state_d = c_IDLE;
                end else begin
                    rx_tmo_d = rx_tmo_q + 1'b1;
                end
            end
            c_BUS: begin
                // Completion is checked first so a done on the last allowed cycle still succeeds.
                if (i_bus_done) begin
                    bus_en_d   = 1'b0;
                    w_start_tx = 1'b1;
                    w_status   = c_ST_OK;
                    if (is_read_q) begin
                        data_d = i_bus_rdata;
                    end
                end else if (bus_tmo_q == c_BUS_LAST) begin
                    bus_en_d   = 1'b0;
                    w_start_tx = 1'b1;
                    w_status   = c_ST_ERR;
                end else begin
                    bus_tmo_d = bus_tmo_q + 1'b1;
                end
            end
            c_TX_STAT: begin
                if (!i_tx_busy) begin
                    if (is_read_q && tx_data_q == c_ST_OK) begin
                        state_d    = c_TX_DATA;
                        byte_cnt_d = 8'd0;
                        tx_data_d  = data_q[DATA_WIDTH-1 -: 8];
                        csum_d     = csum_q ^ data_q[DATA_WIDTH-1 -: 8];
                        data_d     = data_q << 8;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = c_IDLE;
                    end
                end
            end
            c_TX_DATA: begin
                if (!i_tx_busy) begin
                    if (byte_cnt_q == c_DATA_LAST) begin
                        byte_cnt_d = 8'd0;
`ifdef UART_BRIDGE_CHECKSUM_EN
                        state_d   = c_TX_CSUM;
                        tx_data_d = csum_q;
`else
                        tx_valid_d = 1'b0;
                        state_d    = c_IDLE;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        tx_data_d  = data_q[DATA_WIDTH-1 -: 8];
                        csum_d     = csum_q ^ data_q[DATA_WIDTH-1 -: 8];
                        data_d     = data_q << 8;
                    end
                end
            end
`ifdef UART_BRIDGE_CHECKSUM_EN
            c_TX_CSUM: begin
                if (!i_tx_busy) begin
                    tx_valid_d = 1'b0;
                    state_d    = c_IDLE;
                end
            end
`endif
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (w_start_bus) begin
            state_d   = c_BUS;
            bus_en_d  = 1'b1;
            bus_tmo_d = '0;
        end
        // Reply checksum is seeded with the status byte.
        if (w_start_tx) begin
            state_d    = c_TX_STAT;
            tx_valid_d = 1'b1;
            tx_data_d  = w_status;
            csum_d     = w_status;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            byte_cnt_q <= 8'd0;
            addr_q     <= '0;
            data_q     <= '0;
            is_read_q  <= 1'b0;
            csum_q     <= 8'd0;
            rx_tmo_q   <= '0;
            bus_tmo_q  <= '0;
            bus_en_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            is_read_q  <= is_read_d;
            csum_q     <= csum_d;
            rx_tmo_q   <= rx_tmo_d;
            bus_tmo_q  <= bus_tmo_d;
            bus_en_q   <= bus_en_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign o_tx_data     = tx_data_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_bus_address = addr_q;
    assign o_bus_data    = data_q;
    assign o_bus_rnw     = is_read_q;
    assign o_bus_en      = bus_en_q;
    assign o_busy        = (state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_bus_bridge
//  Brief    : Directed self-checking bench for uart_bus_bridge. Expected bus
//             requests and reply bytes are queued when frames are sent and
//             compared when the bridge produces them.
//  Options  : UART_BRIDGE_CHECKSUM_EN -- adds frame/reply checksum steps
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_bus_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BT = 16;
    localparam int RT = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    i_rx_data = 8'd0;
    logic          i_rx_valid = 1'b0;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_busy = 1'b0;
    logic [AW-1:0] o_bus_address;
    logic [DW-1:0] o_bus_data;
    logic          o_bus_rnw;
    logic          o_bus_en;
    logic [DW-1:0] i_bus_rdata = '0;
    logic          i_bus_done = 1'b0;
    logic          o_busy;

    uart_bus_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BUS_TIMEOUT(BT),
        .RX_TIMEOUT (RT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_busy    (i_tx_busy),
        .o_bus_address(o_bus_address),
        .o_bus_data   (o_bus_data),
        .o_bus_rnw    (o_bus_rnw),
        .o_bus_en     (o_bus_en),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_done   (i_bus_done),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rnw;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];
    bus_t       bexp;
    logic [7:0] texp;

    int            n_cmp = 0;
    int            n_err = 0;
    int            done_delay = 1;
    logic [DW-1:0] rdata_resp = '0;
    bit            stall = 1'b0;
    int            en_cnt = 0;
    int            burst_len = 0;
    int            n_bursts = 0;
    bit            en_was = 1'b0;

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bus slave model and reply monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        i_tx_busy  = stall ? ($urandom_range(0, 1) == 1) : 1'b0;
        i_bus_done = 1'b0;
        if (o_bus_en) begin
            en_cnt++;
            if (en_cnt == 1) begin
                n_cmp++;
                if (bus_q.size() == 0) fail("bus request expected", 0, 1);
                if (bus_q.size() != 0) begin
                    bexp = bus_q.pop_front();
                    n_cmp++;
                    if (o_bus_address !== bexp.addr) fail("bus address", o_bus_address, bexp.addr);
                    n_cmp++;
                    if (o_bus_rnw !== bexp.rnw) fail("bus rnw", o_bus_rnw, bexp.rnw);
                    if (!bexp.rnw) begin
                        n_cmp++;
                        if (o_bus_data !== bexp.data) fail("bus wdata", o_bus_data, bexp.data);
                    end
                end
            end
            if (en_cnt == done_delay) begin
                i_bus_done  = 1'b1;
                i_bus_rdata = rdata_resp;
            end
        end else if (en_was) begin
            burst_len = en_cnt;
            n_bursts++;
            en_cnt = 0;
        end
        en_was = o_bus_en;
        if (o_tx_valid && !i_tx_busy) begin
            n_cmp++;
            if (tx_q.size() == 0) fail("tx byte expected", 0, 1);
            if (tx_q.size() != 0) begin
                texp = tx_q.pop_front();
                n_cmp++;
                if (o_tx_data !== texp) fail("tx byte", o_tx_data, texp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input bit bad_csum);
        logic [7:0] cs;
        cs = cmd;
        send_byte(cmd);
        for (int i = AW / 8 - 1; i >= 0; i--) begin
            send_byte(addr[i*8 +: 8]);
            cs ^= addr[i*8 +: 8];
        end
        if (cmd == 8'h57) begin
            for (int i = DW / 8 - 1; i >= 0; i--) begin
                send_byte(data[i*8 +: 8]);
                cs ^= data[i*8 +: 8];
            end
        end
        if (bad_csum) cs = 8'h00;
`ifdef UART_BRIDGE_CHECKSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic push_read_reply(input logic [DW-1:0] data);
        logic [7:0] cs;
        cs = 8'h4B;
        tx_q.push_back(8'h4B);
        for (int i = DW / 8 - 1; i >= 0; i--) begin
            tx_q.push_back(data[i*8 +: 8]);
            cs ^= data[i*8 +: 8];
        end
`ifdef UART_BRIDGE_CHECKSUM_EN
        tx_q.push_back(cs);
`endif
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (o_busy && k < max) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (o_busy !== 1'b0) fail("idle within bound", o_busy, 0);
    endtask

    // Hard stop in case a wait is not bounded as intended.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nb;
        logic [7:0]  junk [3];
        junk = '{8'h00, 8'hFF, 8'h13};

        // Reset state
        tick(3);
        rst = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) fail("reset busy", o_busy, 0);
        n_cmp++; if (o_bus_en !== 1'b0) fail("reset bus_en", o_bus_en, 0);
        n_cmp++; if (o_tx_valid !== 1'b0) fail("reset tx_valid", o_tx_valid, 0);
        n_cmp++; if (o_tx_data !== 8'h00) fail("reset tx_data", o_tx_data, 0);
        n_cmp++; if (o_bus_address !== 32'h0) fail("reset address", o_bus_address, 0);
        n_cmp++; if (o_bus_data !== 32'h0) fail("reset bus data", o_bus_data, 0);
        n_cmp++; if (o_bus_rnw !== 1'b0) fail("reset rnw", o_bus_rnw, 0);

        // Write, slave answers on third cycle, status-only reply
        nb = n_bursts;
        done_delay = 3;
        bus_q.push_back('{addr: 32'hC000_0000, data: 32'h0000_0041, rnw: 1'b0});
        tx_q.push_back(8'h4B);
        send_frame(8'h57, 32'hC000_0000, 32'h0000_0041, 1'b0);
        n_cmp++; if (o_bus_en !== 1'b1) fail("bus_en one cycle after last byte", o_bus_en, 1);
        n_cmp++; if (o_busy !== 1'b1) fail("busy during bus", o_busy, 1);
        wait_idle(200);
        n_cmp++; if (burst_len != 3) fail("write burst length", burst_len, 3);
        n_cmp++; if (n_bursts != nb + 1) fail("write burst count", n_bursts, nb + 1);
        n_cmp++; if (tx_q.size() != 0) fail("write reply drained", tx_q.size(), 0);

        // Read with transmitter stalls
        stall = 1'b1;
        done_delay = 2;
        rdata_resp = 32'h0000_001F;
        bus_q.push_back('{addr: 32'hC000_0008, data: 32'h0, rnw: 1'b1});
        push_read_reply(32'h0000_001F);
        send_frame(8'h52, 32'hC000_0008, 32'h0, 1'b0);
        wait_idle(400);
        stall = 1'b0;
        n_cmp++; if (tx_q.size() != 0) fail("read reply drained", tx_q.size(), 0);
        n_cmp++; if (burst_len != 2) fail("read burst length", burst_len, 2);

        // Slave never answers: error status after exactly BT cycles
        done_delay = 0;
        bus_q.push_back('{addr: 32'h0000_0010, data: 32'h0, rnw: 1'b1});
        tx_q.push_back(8'h45);
        send_frame(8'h52, 32'h0000_0010, 32'h0, 1'b0);
        wait_idle(200);
        n_cmp++; if (burst_len != BT) fail("timeout burst length", burst_len, BT);
        n_cmp++; if (tx_q.size() != 0) fail("timeout reply drained", tx_q.size(), 0);

        // Done on the final allowed cycle beats the timeout
        done_delay = BT;
        rdata_resp = 32'hA5A5_5A5A;
        bus_q.push_back('{addr: 32'h1234_5678, data: 32'h0, rnw: 1'b1});
        push_read_reply(32'hA5A5_5A5A);
        send_frame(8'h52, 32'h1234_5678, 32'h0, 1'b0);
        wait_idle(200);
        n_cmp++; if (burst_len != BT) fail("late done burst length", burst_len, BT);
        n_cmp++; if (tx_q.size() != 0) fail("late done reply drained", tx_q.size(), 0);

        // Partial frame then silence: abandoned without reply
        nb = n_bursts;
        send_byte(8'h52);
        send_byte(8'hC0);
        tick(RT - 5);
        n_cmp++; if (o_busy !== 1'b1) fail("busy before rx timeout", o_busy, 1);
        tick(10);
        n_cmp++; if (o_busy !== 1'b0) fail("idle after rx timeout", o_busy, 0);
        n_cmp++; if (n_bursts != nb) fail("no bus after rx timeout", n_bursts, nb);
        done_delay = 1;
        rdata_resp = 32'h1234_5678;
        bus_q.push_back('{addr: 32'hC000_0004, data: 32'h0, rnw: 1'b1});
        push_read_reply(32'h1234_5678);
        send_frame(8'h52, 32'hC000_0004, 32'h0, 1'b0);
        wait_idle(200);
        n_cmp++; if (tx_q.size() != 0) fail("recovery reply drained", tx_q.size(), 0);
        n_cmp++; if (n_bursts != nb + 1) fail("recovery burst count", n_bursts, nb + 1);

        // Junk bytes in IDLE are ignored
        foreach (junk[i]) begin
            send_byte(junk[i]);
            n_cmp++;
            if (o_busy !== 1'b0) fail("junk ignored", o_busy, 0);
        end

        // Reset in the middle of a bus transaction
        done_delay = 0;
        bus_q.push_back('{addr: 32'h0000_00A0, data: 32'h0000_0055, rnw: 1'b0});
        send_frame(8'h57, 32'h0000_00A0, 32'h0000_0055, 1'b0);
        tick(3);
        n_cmp++; if (o_bus_en !== 1'b1) fail("bus_en before reset", o_bus_en, 1);
        rst = 1'b1;
        tick(1);
        n_cmp++; if (o_bus_en !== 1'b0) fail("bus_en dropped by reset", o_bus_en, 0);
        n_cmp++; if (o_tx_valid !== 1'b0) fail("tx_valid after reset", o_tx_valid, 0);
        rst = 1'b0;
        tick(20);
        n_cmp++; if (o_busy !== 1'b0) fail("idle after reset", o_busy, 0);

`ifdef UART_BRIDGE_CHECKSUM_EN
        // Bad checksum: 'C' reply and no bus request
        nb = n_bursts;
        tx_q.push_back(8'h43);
        send_frame(8'h52, 32'hC000_0004, 32'h0, 1'b1);
        wait_idle(200);
        n_cmp++; if (n_bursts != nb) fail("bad csum no bus", n_bursts, nb);
        n_cmp++; if (tx_q.size() != 0) fail("bad csum reply drained", tx_q.size(), 0);
`endif

        n_cmp++; if (bus_q.size() != 0) fail("bus queue empty", bus_q.size(), 0);
        n_cmp++; if (tx_q.size() != 0) fail("tx queue empty", tx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
